reg_iopattern_trigger: RTL and testbench

Parametrised I/O pattern trigger for the ChipWhisperer capture FPGA. Takes decoded byte streams from several protocol decoders (UART, SPI MOSI/MISO, PDI), selects one, and matches the last DEPTH bytes against a masked pattern held in host registers. It fires a stretched trigger after a programmable number of matches, in one-shot or continuous mode. All logic is synchronous to `clk`; no decoder strobe is used as a clock.

---
 rtl/iopattern_trig_pkg.sv | 35 +++
 rtl/iopattern_match.sv | 67 ++++++
 rtl/reg_iopattern_trigger.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_reg_iopattern_trigger.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iopattern_trig_pkg.sv
// Shared constants and state encoding for the I/O pattern trigger.
// Timeout logic is built only when REG_IOPATTERN_TIMEOUT_EN is defined.
package iopattern_trig_pkg;

  localparam int MAX_DEPTH = 16;
  localparam int FILL_W    = $clog2(MAX_DEPTH + 1);

  localparam int CFG_ADDR_DEF  = 57;
  localparam int DATA_ADDR_DEF = 58;
  localparam int MASK_ADDR_DEF = 59;

  localparam int CFG_LEN  = 8;
  localparam int MASK_LEN = 2;

  localparam int CFG_B_CTRL  = 0;
  localparam int CFG_B_NMAT  = 1;
  localparam int CFG_B_LENLO = 2;
  localparam int CFG_B_LENHI = 3;
  localparam int CFG_B_TOLO  = 4;
  localparam int CFG_B_TOHI  = 5;
  localparam int CFG_B_CNT   = 6;
  localparam int CFG_B_STAT  = 7;

  localparam int CTRL_ARM  = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_SEL  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2,
    ST_DONE  = 2'd3
  } trig_state_e;

endpackage

// File: rtl/iopattern_match.sv
// Byte shift buffer with fill tracking and masked pattern compare.
// match_o pulses for one cycle on the cycle after a matching shift.
module iopattern_match
  import iopattern_trig_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic [7:0]            data_i,
  input  logic [DEPTH-1:0][7:0] pat_i,
  input  logic [DEPTH-1:0]      mask_i,
  output logic                  match_o
);

  logic [DEPTH-1:0][7:0] buf_q;
  logic [FILL_W-1:0]     fill_q;
  logic                  shifted_q;
  logic                  match_q;
  logic                  cmp;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      buf_q     <= '0;
      fill_q    <= '0;
      shifted_q <= 1'b0;
    end else begin
      shifted_q <= shift_i;
      if (shift_i) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          buf_q[i] <= buf_q[i-1];
        end
        buf_q[0] <= data_i;
      end
      if (clr_i) begin
        fill_q <= '0;
      end else if (shift_i && fill_q != FILL_W'(DEPTH)) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

  // An empty mask must never match, hence the reduction seed.
  always_comb begin
    cmp = |mask_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (mask_i[i] &&
          !(fill_q > FILL_W'(i) &&
            buf_q[i] == pat_i[i])) begin
        cmp = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      match_q <= 1'b0;
    end else begin
      match_q <= shifted_q && cmp;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/reg_iopattern_trigger.sv
// Register-mapped I/O pattern trigger over selectable decoder streams.
// Define REG_IOPATTERN_TIMEOUT_EN to build the inter-byte timeout.
module reg_iopattern_trigger
  import iopattern_trig_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int NUM_SRC   = 4,
  parameter int CFG_ADDR  = CFG_ADDR_DEF,
  parameter int DATA_ADDR = DATA_ADDR_DEF,
  parameter int MASK_ADDR = MASK_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic [5:0]           reg_address,
  input  logic [15:0]          reg_bytecnt,
  input  logic [7:0]           reg_datai,
  output logic [7:0]           reg_datao,
  input  logic [15:0]          reg_size,
  input  logic                 reg_read,
  input  logic                 reg_write,
  input  logic                 reg_addrvalid,
  output logic                 reg_stream,
  input  logic [5:0]           reg_hypaddress,
  output logic [15:0]          reg_hyplen,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  output logic                 trig_out
);

  logic [3:0]            ctrl_q;
  logic [3:0]            ctrl_d;
  logic [7:0]            nmat_q;
  logic [15:0]           len_q;
  logic [DEPTH-1:0][7:0] pat_q;
  logic [15:0]           mask_q;
  trig_state_e           state_q;
  logic [7:0]            mcnt_q;
  logic [15:0]           str_q;
  logic                  trig_q;
  logic                  trgd_q;
  logic [7:0]            rdat_q;
  logic [7:0]            rd_d;

  logic sel_cfg;
  logic sel_dat;
  logic sel_msk;
  logic wr_cfg;
  logic wr_dat;
  logic wr_msk;

  assign sel_cfg = reg_address == 6'(CFG_ADDR);
  assign sel_dat = reg_address == 6'(DATA_ADDR);
  assign sel_msk = reg_address == 6'(MASK_ADDR);
  assign wr_cfg  = reg_write && sel_cfg;
  assign wr_dat  = reg_write && sel_dat;
  assign wr_msk  = reg_write && sel_msk;

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_cfg && reg_bytecnt == 16'(CFG_B_CTRL)) begin
      ctrl_d = reg_datai[3:0];
    end
  end

`ifdef REG_IOPATTERN_TIMEOUT_EN
  logic [15:0] to_q;
`endif

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      ctrl_q <= '0;
      nmat_q <= 8'd1;
      len_q  <= 16'd1;
      pat_q  <= '0;
      mask_q <= '0;
`ifdef REG_IOPATTERN_TIMEOUT_EN
      to_q   <= '0;
`endif
    end else begin
      ctrl_q <= ctrl_d;
      if (wr_cfg) begin
        case (reg_bytecnt)
          16'(CFG_B_NMAT):  nmat_q      <= reg_datai;
          16'(CFG_B_LENLO): len_q[7:0]  <= reg_datai;
          16'(CFG_B_LENHI): len_q[15:8] <= reg_datai;
`ifdef REG_IOPATTERN_TIMEOUT_EN
          16'(CFG_B_TOLO):  to_q[7:0]   <= reg_datai;
          16'(CFG_B_TOHI):  to_q[15:8]  <= reg_datai;
`endif
          default: ;
        endcase
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_dat && reg_bytecnt == 16'(i)) begin
          pat_q[i] <= reg_datai;
        end
      end
      if (wr_msk && reg_bytecnt == 16'd0) begin
        mask_q[7:0] <= reg_datai;
      end
      if (wr_msk && reg_bytecnt == 16'd1) begin
        mask_q[15:8] <= reg_datai;
      end
    end
  end

  logic       acc;
  logic [7:0] sdat;
  logic       sel_chg;
  logic       to_clr;
  logic       clr;
  logic       stb;

  // Select values at or above NUM_SRC match no loop index.
  always_comb begin
    acc  = 1'b0;
    sdat = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (ctrl_q[3:2] == 2'(s)) begin
        acc  = src_valid[s];
        sdat = src_data[s*8 +: 8];
      end
    end
  end

  assign sel_chg = ctrl_d[3:2] != ctrl_q[3:2];

`ifdef REG_IOPATTERN_TIMEOUT_EN
  logic [15:0] idle_q;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      idle_q <= '0;
    end else if (acc) begin
      idle_q <= '0;
    end else if (idle_q != 16'hFFFF) begin
      idle_q <= idle_q + 16'd1;
    end
  end

  assign to_clr = (to_q != 16'd0) &&
                  (idle_q >= to_q) && !acc;
`else
  assign to_clr = 1'b0;
`endif

  assign clr = (state_q == ST_IDLE) ||
               sel_chg || to_clr;

  iopattern_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .clk     (clk),
    .rst_i   (reset_i),
    .clr_i   (clr),
    .shift_i (acc),
    .data_i  (sdat),
    .pat_i   (pat_q),
    .mask_i  (mask_q[DEPTH-1:0]),
    .match_o (stb)
  );

  logic [7:0]  n_eff;
  logic [15:0] l_eff;
  logic        hit;
  logic        str_end;
  logic        arm_d;
  logic        cont;

  assign n_eff   = (nmat_q == 8'd0) ? 8'd1 : nmat_q;
  assign l_eff   = (len_q == 16'd0) ? 16'd1 : len_q;
  assign hit     = (9'(mcnt_q) + 9'd1) == 9'(n_eff);
  assign str_end = str_q == (l_eff - 16'd1);
  assign arm_d   = ctrl_d[CTRL_ARM];
  assign cont    = ctrl_q[CTRL_CONT];

  // Looking at arm_d lets a same-cycle disarm beat a match.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      mcnt_q  <= '0;
      str_q   <= '0;
      trig_q  <= 1'b0;
      trgd_q  <= 1'b0;
    end else if (!arm_d) begin
      state_q <= ST_IDLE;
      mcnt_q  <= '0;
      trig_q  <= 1'b0;
      trgd_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_ARMED;
          mcnt_q  <= '0;
        end
        ST_ARMED: begin
          if (stb && hit) begin
            state_q <= ST_FIRE;
            mcnt_q  <= '0;
            str_q   <= '0;
            trig_q  <= 1'b1;
            trgd_q  <= 1'b1;
          end else if (stb) begin
            mcnt_q <= mcnt_q + 8'd1;
          end
        end
        ST_FIRE: begin
          if (cont && stb && hit) begin
            mcnt_q <= '0;
            str_q  <= '0;
          end else begin
            if (cont && stb) begin
              mcnt_q <= mcnt_q + 8'd1;
            end
            if (str_end) begin
              trig_q  <= 1'b0;
              state_q <= cont ? ST_ARMED : ST_DONE;
            end else begin
              str_q <= str_q + 16'd1;
            end
          end
        end
        ST_DONE: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    unique case (1'b1)
      sel_cfg: begin
        case (reg_bytecnt)
          16'(CFG_B_CTRL):  rd_d = {4'b0, ctrl_q};
          16'(CFG_B_NMAT):  rd_d = nmat_q;
          16'(CFG_B_LENLO): rd_d = len_q[7:0];
          16'(CFG_B_LENHI): rd_d = len_q[15:8];
`ifdef REG_IOPATTERN_TIMEOUT_EN
          16'(CFG_B_TOLO):  rd_d = to_q[7:0];
          16'(CFG_B_TOHI):  rd_d = to_q[15:8];
`endif
          16'(CFG_B_CNT):   rd_d = mcnt_q;
          16'(CFG_B_STAT):  rd_d = {5'b0, trgd_q, state_q};
          default:          rd_d = '0;
        endcase
      end
      sel_dat: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (reg_bytecnt == 16'(i)) begin
            rd_d = pat_q[i];
          end
        end
      end
      sel_msk: begin
        if (reg_bytecnt == 16'd0) begin
          rd_d = mask_q[7:0];
        end else if (reg_bytecnt == 16'd1) begin
          rd_d = mask_q[15:8];
        end
      end
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rdat_q <= '0;
    end else if (reg_read) begin
      rdat_q <= rd_d;
    end
  end

  always_comb begin
    reg_hyplen = '0;
    if (reg_hypaddress == 6'(CFG_ADDR)) begin
      reg_hyplen = 16'(CFG_LEN);
    end else if (reg_hypaddress == 6'(DATA_ADDR)) begin
      reg_hyplen = 16'(DEPTH);
    end else if (reg_hypaddress == 6'(MASK_ADDR)) begin
      reg_hyplen = 16'(MASK_LEN);
    end
  end

  logic unused_in;
  assign unused_in = ^{reg_size, reg_addrvalid};

  assign reg_datao  = rdat_q;
  assign reg_stream = 1'b0;
  assign trig_out   = trig_q;

endmodule

// File: tb/tb_reg_iopattern_trigger.sv
// Bench for reg_iopattern_trigger: register table, directed
// sequences and randomized streams against a history model.
module tb_reg_iopattern_trigger;

  localparam logic [5:0] CA = 6'd57;
  localparam logic [5:0] DA = 6'd58;
  localparam logic [5:0] MA = 6'd59;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [5:0]  reg_address = '0;
  logic [15:0] reg_bytecnt = '0;
  logic [7:0]  reg_datai = '0;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size = '0;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic        reg_addrvalid = 1'b0;
  logic        reg_stream;
  logic [5:0]  reg_hypaddress = '0;
  logic [15:0] reg_hyplen;
  logic [31:0] src_data = '0;
  logic [3:0]  src_valid = '0;
  logic        trig_out;

  reg_iopattern_trigger dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_size       (reg_size),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_stream     (reg_stream),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .trig_out       (trig_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         w;
    logic [5:0] a;
    logic [15:0] b;
    logic [7:0] d;
    logic [7:0] e;
  } rv_t;

  rv_t tbl[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] pat[8];
  logic [7:0] mask;
  logic [7:0] hist[$];
  int cnt, neff, leff, fe;
  bit fired;

  function automatic void add(bit w, logic [5:0] a,
      logic [15:0] b, logic [7:0] d, logic [7:0] e);
    tbl.push_back('{w, a, b, d, e});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm,
      input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a,
      input logic [15:0] b, input logic [7:0] d);
    reg_address = a;
    reg_bytecnt = b;
    reg_datai   = d;
    reg_write   = 1'b1;
    tick();
    reg_write   = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a,
      input logic [15:0] b, output logic [7:0] d);
    reg_address = a;
    reg_bytecnt = b;
    reg_read    = 1'b1;
    tick();
    reg_read    = 1'b0;
    d = reg_datao;
  endtask

  task automatic send(input int s, input logic [7:0] v);
    src_data[s*8 +: 8] = v;
    src_valid    = '0;
    src_valid[s] = 1'b1;
    tick();
    src_valid    = '0;
  endtask

  task automatic do_rst();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic watch(input int n,
      output int first, output int len);
    first = -1;
    len = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (trig_out) begin
        if (first < 0) first = i;
        len++;
      end
    end
  endtask

  function automatic bit model_match();
    if (mask == 8'h00) return 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        if (i >= hist.size()) return 1'b0;
        if (hist[hist.size()-1-i] != pat[i]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic tchk();
    logic e;
    e = fired && cyc >= fe + 2 && cyc <= fe + 1 + leff;
    chk("rand_trig", 16'(trig_out), 16'(e));
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] to_exp;
    int f, l, sel, nraw, lraw, gap;
    int ha[4];
    int hl[4];

`ifdef REG_IOPATTERN_TIMEOUT_EN
    to_exp = 8'h64;
`else
    to_exp = 8'h00;
`endif
    add(0, CA, 0, 0, 8'h00);
    add(0, CA, 1, 0, 8'h01);
    add(0, CA, 2, 0, 8'h01);
    add(0, CA, 3, 0, 8'h00);
    add(0, CA, 7, 0, 8'h00);
    add(0, MA, 0, 0, 8'h00);
    add(0, DA, 3, 0, 8'h00);
    add(1, CA, 1, 8'h05, 8'h05);
    add(1, CA, 6, 8'hAA, 8'h00);
    add(1, CA, 7, 8'hFF, 8'h00);
    add(1, DA, 7, 8'h3C, 8'h3C);
    add(1, DA, 8, 8'h77, 8'h00);
    add(1, MA, 1, 8'h81, 8'h81);
    add(1, MA, 2, 8'h11, 8'h00);
    add(1, CA, 4, 8'h64, to_exp);
    add(1, CA, 8, 8'h12, 8'h00);
    add(1, CA, 0, 8'hFC, 8'h0C);
    add(0, 6'd10, 0, 0, 8'h00);

    do_rst();
    chk("rst_trig", 16'(trig_out), 16'd0);
    chk("rst_datao", 16'(reg_datao), 16'd0);
    chk("stream", 16'(reg_stream), 16'd0);

    foreach (tbl[i]) begin
      if (tbl[i].w) wr(tbl[i].a, tbl[i].b, tbl[i].d);
      rd(tbl[i].a, tbl[i].b, d);
      chk($sformatf("reg%0d", i), 16'(d), 16'(tbl[i].e));
    end

    ha = '{57, 58, 59, 3};
    hl = '{8, 8, 2, 0};
    for (int i = 0; i < 4; i++) begin
      reg_hypaddress = 6'(ha[i]);
      #1;
      chk("hyplen", reg_hyplen, 16'(hl[i]));
    end

    // single match, one-shot
    do_rst();
    wr(MA, 0, 8'h01);
    wr(DA, 0, 8'hA5);
    wr(CA, 2, 8'd4);
    wr(CA, 0, 8'h01);
    repeat (3) tick();
    send(0, 8'hA5);
    watch(10, f, l);
    chk("single_first", 16'(f), 16'd2);
    chk("single_len", 16'(l), 16'd4);
    rd(CA, 7, d);
    chk("single_stat", 16'(d), 16'h07);
    send(0, 8'hA5);
    watch(6, f, l);
    chk("oneshot_rearm", 16'(l), 16'd0);

    // match count N=3
    do_rst();
    wr(MA, 0, 8'h03);
    wr(DA, 0, 8'h34);
    wr(DA, 1, 8'h12);
    wr(CA, 1, 8'd3);
    wr(CA, 2, 8'd2);
    wr(CA, 0, 8'h01);
    repeat (3) tick();
    rd(CA, 6, d);
    chk("cnt0", 16'(d), 16'd0);
    for (int p = 0; p < 3; p++) begin
      send(0, 8'h12);
      send(0, 8'h34);
      watch(6, f, l);
      rd(CA, 6, d);
      if (p < 2) begin
        chk("cnt_notrig", 16'(l), 16'd0);
        chk("cnt_val", 16'(d), 16'(p + 1));
      end else begin
        chk("cnt_first", 16'(f), 16'd2);
        chk("cnt_len", 16'(l), 16'd2);
        chk("cnt_clr", 16'(d), 16'd0);
      end
    end

    // partial fill on source 1
    do_rst();
    wr(MA, 0, 8'hFF);
    for (int i = 0; i < 8; i++) wr(DA, 16'(i), 8'h66);
    wr(CA, 0, 8'h05);
    repeat (3) tick();
    for (int j = 0; j < 7; j++) send(1, 8'h66);
    watch(4, f, l);
    chk("fill7", 16'(l), 16'd0);
    send(1, 8'h66);
    watch(4, f, l);
    chk("fill8_first", 16'(f), 16'd2);
    chk("fill8_len", 16'(l), 16'd1);

    // continuous restart
    do_rst();
    wr(MA, 0, 8'h01);
    wr(DA, 0, 8'h99);
    wr(CA, 2, 8'd6);
    wr(CA, 0, 8'h03);
    repeat (3) tick();
    send(0, 8'h99);
    f = -1;
    l = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin
        src_data[7:0] = 8'h99;
        src_valid[0] = 1'b1;
      end
      tick();
      src_valid = '0;
      if (trig_out) begin
        if (f < 0) f = i;
        l++;
      end
    end
    chk("cont_first", 16'(f), 16'd2);
    chk("cont_len", 16'(l), 16'd9);
    rd(CA, 7, d);
    chk("cont_stat", 16'(d), 16'h05);

    // disarm in the match_stb cycle
    send(0, 8'h99);
    tick();
    wr(CA, 0, 8'h02);
    watch(6, f, l);
    chk("disarm_len", 16'(l), 16'd0);
    rd(CA, 7, d);
    chk("disarm_stat", 16'(d), 16'h00);

    // inter-byte timeout
    do_rst();
    wr(MA, 0, 8'h03);
    wr(DA, 1, 8'h21);
    wr(DA, 0, 8'h43);
    wr(CA, 4, 8'd100);
    wr(CA, 0, 8'h03);
    repeat (3) tick();
    send(0, 8'h21);
    repeat (150) tick();
    send(0, 8'h43);
    watch(5, f, l);
`ifdef REG_IOPATTERN_TIMEOUT_EN
    chk("to_long", 16'(l), 16'd0);
`else
    chk("to_long", 16'(l), 16'd1);
`endif
    send(0, 8'h21);
    repeat (50) tick();
    send(0, 8'h43);
    watch(5, f, l);
    chk("to_short", 16'(l), 16'd1);

    // reset during FIRE
    do_rst();
    wr(MA, 0, 8'h01);
    wr(DA, 0, 8'h5A);
    wr(CA, 2, 8'd20);
    wr(CA, 0, 8'h01);
    repeat (3) tick();
    send(0, 8'h5A);
    repeat (4) tick();
    chk("fire_hi", 16'(trig_out), 16'd1);
    #2 reset_i = 1'b1;
    #1 chk("rst_async", 16'(trig_out), 16'd0);
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd(tbl[i].a, tbl[i].b, d);
      chk("rst_default", 16'(d), 16'(tbl[i].e));
    end

    // randomized one-shot streams
    for (int t = 0; t < 20; t++) begin
      do_rst();
      sel  = $urandom_range(0, 3);
      nraw = $urandom_range(0, 3);
      lraw = $urandom_range(0, 5);
      neff = (nraw == 0) ? 1 : nraw;
      leff = (lraw == 0) ? 1 : lraw;
      mask = 8'($urandom & $urandom);
      for (int i = 0; i < 8; i++) begin
        pat[i] = $urandom_range(0, 1) ? 8'h5A : 8'hC3;
        wr(DA, 16'(i), pat[i]);
      end
      wr(MA, 0, mask);
      wr(CA, 1, 8'(nraw));
      wr(CA, 2, 8'(lraw));
      wr(CA, 0, {4'b0, 2'(sel), 2'b01});
      repeat (3) tick();
      hist.delete();
      cnt = 0;
      fired = 0;
      fe = 0;
      for (int k = 0; k < 24; k++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          tick();
          tchk();
        end
        d = $urandom_range(0, 1) ? 8'h5A : 8'hC3;
        for (int s = 0; s < 4; s++) begin
          src_valid[s] = 1'($urandom_range(0, 1));
          src_data[s*8 +: 8] = 8'($urandom);
        end
        src_valid[sel] = 1'b1;
        src_data[sel*8 +: 8] = d;
        tick();
        src_valid = '0;
        hist.push_back(d);
        if (!fired && model_match()) begin
          cnt++;
          if (cnt == neff) begin
            fired = 1;
            fe = cyc;
            cnt = 0;
          end
        end
        tchk();
      end
      repeat (leff + 4) begin
        tick();
        tchk();
      end
      rd(CA, 7, d);
      chk("rand_stat", 16'(d), fired ? 16'h07 : 16'h01);
      rd(CA, 6, d);
      chk("rand_cnt", 16'(d), 16'(cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
